fifo_asymmetric_downsize: RTL and testbench

Single-clock asymmetric FIFO: accepts wide words (WR_DATA_WIDTH) and returns them as narrow words (RD_DATA_WIDTH), least-significant slice first. It is the width-reducing counterpart of fifo_asymmetric, which packs narrow writes into wide reads. It is used where wide buffer or memory data must be serialised into a narrow datapath, for example 16-bit buffer words feeding an 8-bit PE lane.

---
 rtl/fifo_asymmetric_downsize_pkg.sv | 22 ++
 rtl/fifo_asymmetric_downsize_ram.sv | 47 ++++
 rtl/fifo_asymmetric_downsize.sv | 97 +++++++++
 tb/tb_fifo_asymmetric_downsize.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/fifo_asymmetric_downsize_pkg.sv
// Shared widths, derived constants and the legality rule for the wide-in /
// narrow-out FIFO.
package fifo_asymmetric_downsize_pkg;

   localparam int DEF_WR_DATA_WIDTH = 16;
   localparam int DEF_RD_DATA_WIDTH = 8;
   localparam int DEF_WR_ADDR_WIDTH = 3;
   localparam int DEF_RD_ADDR_WIDTH = 4;

   localparam int RATIO    = DEF_WR_DATA_WIDTH / DEF_RD_DATA_WIDTH;
   localparam int SUB_BITS = $clog2(RATIO);
   localparam int CAP      = 1 << DEF_RD_ADDR_WIDTH;

   function automatic bit widths_legal(input int wr_dw, input int rd_dw,
                                       input int wr_aw, input int rd_aw);
      int ratio;
      ratio = wr_dw / rd_dw;
      return (rd_dw > 0) && (ratio >= 2) && (ratio * rd_dw == wr_dw) &&
             ((ratio & (ratio - 1)) == 0) && (rd_aw == wr_aw + $clog2(ratio));
   endfunction

endpackage

// File: rtl/fifo_asymmetric_downsize_ram.sv
// Simple dual-port storage: wide synchronous write, registered narrow read
// selected from one wide slot by the low read-address bits.
module fifo_asym_ram
   import fifo_asymmetric_downsize_pkg::*;
#(
   parameter int WR_DATA_WIDTH = DEF_WR_DATA_WIDTH,
   parameter int RD_DATA_WIDTH = DEF_RD_DATA_WIDTH,
   parameter int WR_ADDR_WIDTH = DEF_WR_ADDR_WIDTH,
   parameter int RD_ADDR_WIDTH = DEF_RD_ADDR_WIDTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [WR_ADDR_WIDTH-1:0] wr_addr,
   input  logic [WR_DATA_WIDTH-1:0] wr_data,
   input  logic                     rd_en,
   input  logic [RD_ADDR_WIDTH-1:0] rd_addr,
   output logic [RD_DATA_WIDTH-1:0] rd_data
);

   localparam int L_RATIO    = WR_DATA_WIDTH / RD_DATA_WIDTH;
   localparam int L_SUB_BITS = $clog2(L_RATIO);

   logic [WR_DATA_WIDTH-1:0] mem [2**WR_ADDR_WIDTH];
   logic [WR_DATA_WIDTH-1:0] rd_word;
   logic [RD_DATA_WIDTH-1:0] slices [L_RATIO];

   // Storage is deliberately not reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
   end

   assign rd_word = mem[rd_addr[RD_ADDR_WIDTH-1:L_SUB_BITS]];

   for (genvar s = 0; s < L_RATIO; s++) begin : g_slice
      assign slices[s] = rd_word[s*RD_DATA_WIDTH +: RD_DATA_WIDTH];
   end

   always_ff @(posedge clk) begin
      if (!reset)
         rd_data <= '0;
      else if (rd_en)
         rd_data <= slices[rd_addr[L_SUB_BITS-1:0]];
   end

endmodule

// File: rtl/fifo_asymmetric_downsize.sv
// Single-clock FIFO taking wide words and returning them as narrow words,
// least-significant slice first. Pointers, occupancy and flags live here.
module fifo_asymmetric_downsize
   import fifo_asymmetric_downsize_pkg::*;
#(
   parameter int WR_DATA_WIDTH = DEF_WR_DATA_WIDTH,
   parameter int RD_DATA_WIDTH = DEF_RD_DATA_WIDTH,
   parameter int WR_ADDR_WIDTH = DEF_WR_ADDR_WIDTH,
   parameter int RD_ADDR_WIDTH = DEF_RD_ADDR_WIDTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     w_req,
   input  logic                     r_req,
   input  logic [WR_DATA_WIDTH-1:0] write_data,
   output logic [RD_DATA_WIDTH-1:0] read_data,
   output logic                     r_ready,
   output logic                     w_ready,
   output logic                     almost_full,
   output logic                     almost_empty
);

   localparam int CW      = RD_ADDR_WIDTH + 1;
   localparam int L_RATIO = WR_DATA_WIDTH / RD_DATA_WIDTH;
   localparam int L_CAP   = 1 << RD_ADDR_WIDTH;

   localparam logic [CW-1:0] RATIO_C    = CW'(L_RATIO);
   localparam logic [CW-1:0] RATIO_M1_C = CW'(L_RATIO - 1);
   localparam logic [CW-1:0] ONE_C      = CW'(1);
   localparam logic [CW-1:0] WR_LIMIT_C = CW'(L_CAP - L_RATIO);
   localparam logic [WR_ADDR_WIDTH-1:0] WR_INC_C = WR_ADDR_WIDTH'(1);
   localparam logic [RD_ADDR_WIDTH-1:0] RD_INC_C = RD_ADDR_WIDTH'(1);

   if (!widths_legal(WR_DATA_WIDTH, RD_DATA_WIDTH, WR_ADDR_WIDTH, RD_ADDR_WIDTH)) begin : g_bad_widths
      $error("fifo_asymmetric_downsize: illegal width/depth parameters");
   end

   logic [WR_ADDR_WIDTH-1:0] wr_ptr;
   logic [RD_ADDR_WIDTH-1:0] rd_ptr;
   logic [CW-1:0]            count;
   logic                     wr_en;
   logic                     rd_en;
   logic [CW-1:0]            count_nxt;

   // Handshake: a write transfers on a rising edge where w_req && w_ready, a
   // read where r_req && r_ready; both readies come from the pre-edge count,
   // requests while not ready are ignored, and read_data is valid the cycle
   // after an accepted read and holds until the next one.
   assign w_ready      = (count <= WR_LIMIT_C);
   assign r_ready      = (count != '0);
   assign almost_full  = (count >= WR_LIMIT_C);
   assign almost_empty = (count <= ONE_C);

   assign wr_en = w_req && w_ready;
   assign rd_en = r_req && r_ready;

   always_comb begin
      count_nxt = count;
      case ({wr_en, rd_en})
         2'b10:   count_nxt = count + RATIO_C;
         2'b01:   count_nxt = count - ONE_C;
         2'b11:   count_nxt = count + RATIO_M1_C;
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + WR_INC_C;
         if (rd_en)
            rd_ptr <= rd_ptr + RD_INC_C;
         count <= count_nxt;
      end
   end

   fifo_asym_ram #(
      .WR_DATA_WIDTH(WR_DATA_WIDTH),
      .RD_DATA_WIDTH(RD_DATA_WIDTH),
      .WR_ADDR_WIDTH(WR_ADDR_WIDTH),
      .RD_ADDR_WIDTH(RD_ADDR_WIDTH)
   ) u_ram (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (write_data),
      .rd_en   (rd_en),
      .rd_addr (rd_ptr),
      .rd_data (read_data)
   );

endmodule

// File: tb/tb_fifo_asymmetric_downsize.sv
// Randomised scoreboard bench for fifo_asymmetric_downsize against a
// byte-queue reference model.
module tb_fifo_asymmetric_downsize;

   localparam int WDW   = 16;
   localparam int RDW   = 8;
   localparam int RATIO = WDW / RDW;
   localparam int CAP   = 16;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic           w_req = 1'b0;
   logic           r_req = 1'b0;
   logic [WDW-1:0] write_data = '0;
   logic [RDW-1:0] read_data;
   logic           r_ready;
   logic           w_ready;
   logic           almost_full;
   logic           almost_empty;

   int checks = 0;
   int errors = 0;

   logic [RDW-1:0] model_q[$];
   logic [RDW-1:0] exp_q[$];
   logic [RDW-1:0] last_exp = '0;

   fifo_asymmetric_downsize dut (
      .clk          (clk),
      .reset        (reset),
      .w_req        (w_req),
      .r_req        (r_req),
      .write_data   (write_data),
      .read_data    (read_data),
      .r_ready      (r_ready),
      .w_ready      (w_ready),
      .almost_full  (almost_full),
      .almost_empty (almost_empty)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_flags();
      int n;
      n = model_q.size();
      check("w_ready", 32'(w_ready), 32'(n <= CAP - RATIO));
      check("r_ready", 32'(r_ready), 32'(n != 0));
      check("almost_full", 32'(almost_full), 32'(n >= CAP - RATIO));
      check("almost_empty", 32'(almost_empty), 32'(n <= 1));
   endtask

   // driver: called at a falling edge, returns at the next falling edge
   task automatic cycle(input logic w, input logic r, input logic [WDW-1:0] d);
      bit w_acc, r_acc;
      w_req = w;
      r_req = r;
      write_data = d;
      check_flags();
      w_acc = w && (model_q.size() <= CAP - RATIO);
      r_acc = r && (model_q.size() != 0);
      if (r_acc)
         exp_q.push_back(model_q.pop_front());
      if (w_acc)
         for (int s = 0; s < RATIO; s++)
            model_q.push_back(d[s*RDW +: RDW]);
      @(posedge clk);
      @(negedge clk);
      w_req = 1'b0;
      r_req = 1'b0;
   endtask

   task automatic reset_cycle(input logic w, input logic r);
      reset = 1'b0;
      w_req = w;
      r_req = r;
      write_data = 16'hDEAD;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      w_req = 1'b0;
      r_req = 1'b0;
      model_q.delete();
      exp_q.delete();
   endtask

   task automatic reads(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, '0);
   endtask

   // monitor / scoreboard: read_data must hold except after an accepted read
   always @(posedge clk) begin
      bit fire;
      bit rst;
      rst  = (reset === 1'b0);
      fire = !rst && (r_req === 1'b1) && (r_ready === 1'b1);
      #1;
      if (rst) begin
         last_exp = '0;
      end else if (fire) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_read: got %0h expected no read (t=%0t)", read_data, $time);
         end else begin
            last_exp = exp_q.pop_front();
         end
      end
      check("read_data", 32'(read_data), 32'(last_exp));
   end

   initial begin
      @(negedge clk);
      reset_cycle(1'b0, 1'b0);
      reset_cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0, '0);

      // ordering: low slice first
      cycle(1'b1, 1'b0, 16'hA1A0);
      cycle(1'b1, 1'b0, 16'hA3A2);
      reads(4);
      cycle(1'b0, 1'b1, '0);          // read while empty is ignored
      cycle(1'b0, 1'b0, '0);

      // fill plus one refused write
      for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 16'(16'h0100 + i));
      cycle(1'b0, 1'b0, '0);

      // partial slot: one read does not free a wide slot, two do
      reads(1);
      cycle(1'b1, 1'b0, 16'hBEEF);    // refused at count 15
      reads(1);
      cycle(1'b1, 1'b0, 16'hC1C0);    // accepted at count 14
      cycle(1'b0, 1'b0, '0);

      // simultaneous read/write at count 3
      reads(13);
      cycle(1'b1, 1'b1, 16'hD1D0);
      cycle(1'b0, 1'b0, '0);
      reads(4);

      // random interleaving across pointer wrap
      for (int i = 0; i < 300; i++)
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0), 16'($urandom));
      reads(CAP + 1);

      // reset mid-operation with both requests asserted
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 16'(16'hE000 + i));
      reads(1);
      reset_cycle(1'b1, 1'b1);
      cycle(1'b0, 1'b1, '0);
      cycle(1'b1, 1'b0, 16'h5A4B);
      reads(3);
      cycle(1'b0, 1'b0, '0);

      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
